// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS core: opcodes, control-FSM state
// encodings, ALUOp and PCSrc codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_WB_MEM   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_EXEC_R   = 4'd6;
    localparam logic [3:0] ST_WB_R     = 4'd7;
    localparam logic [3:0] ST_EXEC_I   = 4'd8;
    localparam logic [3:0] ST_WB_I     = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM with sticky illegal-opcode flag and retired counter.
// Latency (mem_ready=1): R/ADDI/SW 4 cycles, LW 5, BEQ/J 3; each wait cycle adds 1.
// Backpressure: FETCH/MEM_RD/MEM_WR hold mem_req and address select until mem_ready.
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] retired
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       retire;
    logic       illegal_set;

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        illegal_set = 1'b0;
        case (state)
            ST_FETCH:    if (mem_ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
                    OP_RTYPE:     state_nxt = ST_EXEC_R;
                    OP_ADDI:      state_nxt = ST_EXEC_I;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_J:         state_nxt = ST_JUMP;
                    default: begin
                        state_nxt   = ST_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: state_nxt = (Opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_nxt = ST_WB_MEM;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_nxt = ST_FETCH;
                    retire    = 1'b1;
                end
            end
            ST_EXEC_R:   state_nxt = ST_WB_R;
            ST_EXEC_I:   state_nxt = ST_WB_I;
            ST_WB_MEM, ST_WB_R, ST_WB_I, ST_BRANCH, ST_JUMP: begin
                state_nxt = ST_FETCH;
                retire    = 1'b1;
            end
            default:     state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (illegal_set) illegal <= 1'b1;
            if (retire)      retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Moore decode of state; only the FETCH and BRANCH PC/IR enables see inputs.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE:   alu_src_b = SRCB_IMM2;
            ST_MEM_ADDR, ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_WB_I:     reg_write = 1'b1;
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = Zero;
            end
            ST_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm at CNT_W=4 so counter wrap is reachable.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       Opcode;
    logic             Zero;
    logic             mem_ready;
    logic             mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic             alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0]       state_out;
    logic [CNT_W-1:0] retired;

    int vectors = 0;
    int miscompares = 0;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state_out(state_out), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic z, input logic rdy);
        Opcode    = op;
        Zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(6'h00, 1'b0, 1'b0);
        #2;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        chk("rst_ir_write_nordy", 32'(ir_write), 32'd0);
        tick();
        reset = 1'b0;

        // FETCH waits while memory is busy
        drive(6'h00, 1'b0, 1'b0);
        chk("fetch_hold_pcw", 32'(pc_write), 32'd0);
        tick();
        chk("fetch_hold_state", 32'(state_out), 32'd0);

        // R-type: 0,1,6,7,0
        drive(6'h00, 1'b0, 1'b1);
        chk("r_fetch_irw_pcw", {30'd0, ir_write, pc_write}, 32'h3);
        chk("r_fetch_srcb", 32'(alu_src_b), 32'd1);
        tick();
        drive(6'h00, 1'b0, 1'b1);
        chk("r_decode_state", 32'(state_out), 32'd1);
        chk("r_decode_srcb", 32'(alu_src_b), 32'd3);
        tick();
        chk("r_exec_state", 32'(state_out), 32'd6);
        chk("r_exec_aluop", {29'd0, alu_src_a, alu_op}, 32'b110);
        tick();
        chk("r_wb_state", 32'(state_out), 32'd7);
        chk("r_wb_ctl", {29'd0, reg_write, reg_dst, mem_to_reg}, 32'b110);
        chk("r_wb_retired", 32'(retired), 32'd0);
        tick();
        chk("r_done_state", 32'(state_out), 32'd0);
        chk("r_done_retired", 32'(retired), 32'd1);

        // LW with three wait cycles in MEM_RD: 8 cycles in total
        drive(6'h23, 1'b0, 1'b1);
        tick();
        chk("lw_decode", 32'(state_out), 32'd1);
        tick();
        chk("lw_memaddr", 32'(state_out), 32'd2);
        chk("lw_memaddr_src", {29'd0, alu_src_a, alu_src_b}, 32'b110);
        drive(6'h23, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_memrd_wait", {27'd0, state_out, mem_req}, {27'd0, 4'd3, 1'b1});
            chk("lw_memrd_iord_we", {30'd0, iord, mem_we}, 32'b10);
            tick();
        end
        drive(6'h23, 1'b0, 1'b1);
        chk("lw_memrd_last", {26'd0, state_out, mem_req, iord}, {26'd0, 4'd3, 2'b11});
        tick();
        chk("lw_wbmem_state", 32'(state_out), 32'd4);
        chk("lw_wbmem_ctl", {29'd0, reg_write, reg_dst, mem_to_reg}, 32'b101);
        tick();
        chk("lw_done", {28'd0, state_out}, 32'd0);
        chk("lw_retired", 32'(retired), 32'd2);

        // SW with memory ready immediately
        drive(6'h2B, 1'b0, 1'b1);
        tick(); tick(); tick();
        chk("sw_memwr", {29'd0, mem_req, iord, mem_we}, 32'b111);
        chk("sw_memwr_state", 32'(state_out), 32'd5);
        tick();
        chk("sw_retired", {24'd0, state_out, retired}, {24'd0, 4'd0, 4'd3});

        // BEQ taken
        drive(6'h04, 1'b1, 1'b1);
        tick(); tick();
        chk("beq_t_state", 32'(state_out), 32'd10);
        chk("beq_t_ctl", {25'd0, pc_write, pc_src, alu_src_a, alu_op}, {25'd0, 1'b1, 2'b01, 1'b1, 2'b01});
        tick();
        chk("beq_t_retired", 32'(retired), 32'd4);

        // BEQ not taken still retires
        drive(6'h04, 1'b0, 1'b1);
        tick(); tick();
        chk("beq_nt_pcw", {28'd0, state_out[2:0], pc_write}, {28'd0, 3'd2, 1'b0});
        tick();
        chk("beq_nt_retired", 32'(retired), 32'd5);

        // Illegal opcode returns to FETCH without retiring
        drive(6'h3F, 1'b0, 1'b1);
        tick();
        chk("ill_decode", {27'd0, state_out, illegal}, {27'd0, 4'd1, 1'b0});
        tick();
        chk("ill_state", 32'(state_out), 32'd0);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_retired", 32'(retired), 32'd5);

        // J after illegal; flag stays set
        drive(6'h02, 1'b0, 1'b1);
        tick(); tick();
        chk("j_state", 32'(state_out), 32'd11);
        chk("j_ctl", {29'd0, pc_write, pc_src}, 32'b110);
        chk("j_illegal_sticky", 32'(illegal), 32'd1);
        tick();
        chk("j_retired", 32'(retired), 32'd6);

        // ADDI path
        drive(6'h08, 1'b0, 1'b1);
        tick(); tick();
        chk("addi_exec", {26'd0, state_out, alu_src_b}, {26'd0, 4'd8, 2'b10});
        tick();
        chk("addi_wb", {24'd0, state_out, reg_write, reg_dst, mem_to_reg, 1'b0}, {24'd0, 4'd9, 4'b1000});
        tick();
        chk("addi_retired", 32'(retired), 32'd7);

        // Asynchronous reset in the middle of a stalled MEM_RD
        drive(6'h23, 1'b0, 1'b1);
        tick(); tick();
        drive(6'h23, 1'b0, 1'b0);
        tick();
        chk("midrst_pre", 32'(state_out), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_state", 32'(state_out), 32'd0);
        chk("midrst_req_iord", {30'd0, mem_req, iord}, 32'b10);
        chk("midrst_retired", 32'(retired), 32'd0);
        chk("midrst_illegal", 32'(illegal), 32'd0);
        tick();
        reset = 1'b0;

        // Fill the 4-bit counter with J instructions, then wrap
        drive(6'h02, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick(); tick(); tick();
        end
        chk("wrap_pre", {24'd0, state_out, retired}, {24'd0, 4'd0, 4'hF});
        tick(); tick();
        chk("wrap_jump", 32'(state_out), 32'd11);
        tick();
        chk("wrap_retired", 32'(retired), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
